// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and its neighbours.
//   INST_WIDTH    : instruction word width
//   OP_*          : primary opcode values (inst[31:26]) seen by the decoder
//   fetch_state_t : fetch sequencer states
package cpu_pkg;

    localparam int INST_WIDTH = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        FETCH    = 2'd1,
        VALID    = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_pc_next.sv
// Next-PC selection for the fetch stage (purely combinational).
//   pc_plus4      : address following the latched instruction
//   branch_offset : sign-extended word offset from the decoder
//   take_branch   : branch resolved taken
//   next_pc       : pc_plus4, or pc_plus4 + offset*4 when taken
// All sums wrap modulo 2^ADDR_WIDTH; the top two offset bits fall off the
// shift, and negative offsets work through two's complement.
module pc_next #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] pc_plus4,
    input  logic [31:0]           branch_offset,
    input  logic                  take_branch,
    output logic [ADDR_WIDTH-1:0] next_pc
);

    logic [ADDR_WIDTH-1:0] offset_bytes;

    assign offset_bytes = ADDR_WIDTH'(branch_offset << 2);
    assign next_pc      = take_branch ? (pc_plus4 + offset_bytes) : pc_plus4;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, requests instruction words over a ready
// handshake, latches the returned word and holds it while downstream stalls.
//   clk, reset         : clock, synchronous active-high reset
//   imem_req/addr      : request strobe and fetch address (addr = pc)
//   imem_ready/rdata   : memory response, sampled only while fetching
//   stall              : downstream cannot accept the held instruction
//   branch, zero       : branch decision inputs (taken = branch & zero)
//   branch_offset      : sign-extended word offset for taken branches
//   inst, inst_valid   : latched instruction and its valid flag
//   ctl_op             : inst[31:26] for the decoder
//   pc_plus4           : address of latched instruction + 4
//
// state    | meaning
// RST_WAIT | idle for one cycle after reset, no request
// FETCH    | imem_req high, waiting for imem_ready
// VALID    | instruction held for downstream until stall drops
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    input  logic                  stall,
    input  logic                  branch,
    input  logic                  zero,
    input  logic [31:0]           branch_offset,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  inst_valid,
    output logic [5:0]            ctl_op,
    output logic [ADDR_WIDTH-1:0] pc_plus4
);

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] seq_pc;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  capture;
    logic                  release_inst;

    assign seq_pc    = pc + ADDR_WIDTH'(4);
    assign imem_addr = pc;
    assign ctl_op    = inst[31:26];

    pc_next #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pc_next (
        .pc_plus4      (pc_plus4),
        .branch_offset (branch_offset),
        .take_branch   (branch & zero),
        .next_pc       (next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RST_WAIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        imem_req     = 1'b0;
        inst_valid   = 1'b0;
        capture      = 1'b0;
        release_inst = 1'b0;
        case (state)
            RST_WAIT: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    capture    = 1'b1;
                    state_next = VALID;
                end
            end
            VALID: begin
                inst_valid = 1'b1;
                // Stall wins over branch: branch/zero are only looked at on
                // the cycle the stall drops.
                if (!stall) begin
                    release_inst = 1'b1;
                    state_next   = FETCH;
                end
            end
            default: begin
                state_next = RST_WAIT;
            end
        endcase
    end

    // pc already equals pc_plus4 once a word is captured, so an untaken
    // release leaves it where it is (next_pc == pc_plus4 in that case).
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            inst     <= '0;
            pc_plus4 <= RESET_PC + ADDR_WIDTH'(4);
        end else if (capture) begin
            inst     <= imem_rdata;
            pc_plus4 <= seq_pc;
            pc       <= seq_pc;
        end else if (release_inst) begin
            pc       <= next_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    import cpu_pkg::*;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h8C22_0004;
        return {a[7:2], 26'h0} | (a ^ 32'h0013_5700);
    endfunction

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch;
    logic        zero;
    logic [31:0] branch_offset;
    logic [31:0] inst;
    logic        inst_valid;
    logic [5:0]  ctl_op;
    logic [31:0] pc_plus4;

    assign imem_rdata = mem_word(imem_addr);

    instruction_fetch #(
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch        (branch),
        .zero          (zero),
        .branch_offset (branch_offset),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .ctl_op        (ctl_op),
        .pc_plus4      (pc_plus4)
    );

    // Second instance starting just below the top of the address space.
    logic        w_reset;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ready;
    logic [31:0] w_rdata;
    logic        w_stall;
    logic        w_branch;
    logic        w_zero;
    logic [31:0] w_off;
    logic [31:0] w_inst;
    logic        w_valid;
    logic [5:0]  w_op;
    logic [31:0] w_pc4;

    assign w_rdata = mem_word(w_addr);

    instruction_fetch #(
        .ADDR_WIDTH (32),
        .RESET_PC   (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk           (clk),
        .reset         (w_reset),
        .imem_req      (w_req),
        .imem_addr     (w_addr),
        .imem_ready    (w_ready),
        .imem_rdata    (w_rdata),
        .stall         (w_stall),
        .branch        (w_branch),
        .zero          (w_zero),
        .branch_offset (w_off),
        .inst          (w_inst),
        .inst_valid    (w_valid),
        .ctl_op        (w_op),
        .pc_plus4      (w_pc4)
    );

    typedef struct {
        int          delay;
        int          stall_cyc;
        logic        br;
        logic        z;
        logic [31:0] off;
        logic [31:0] exp_addr;
        logic [31:0] exp_next;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves it in the next FETCH.
    task automatic fetch_one(input int idx, input vec_t v);
        exp_t e;
        chk($sformatf("v%0d req", idx), 32'(imem_req), 32'd1);
        chk($sformatf("v%0d addr", idx), imem_addr, v.exp_addr);
        chk($sformatf("v%0d valid_fetch", idx), 32'(inst_valid), 32'd0);
        for (int i = 0; i < v.delay; i++) begin
            imem_ready = 1'b0;
            step();
            chk($sformatf("v%0d wait_req", idx), 32'(imem_req), 32'd1);
            chk($sformatf("v%0d wait_addr", idx), imem_addr, v.exp_addr);
            chk($sformatf("v%0d wait_valid", idx), 32'(inst_valid), 32'd0);
        end
        imem_ready = 1'b1;
        sb.push_back('{mem_word(v.exp_addr), v.exp_addr + 32'd4});
        step();
        imem_ready = 1'b0;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL v%0d scoreboard empty", idx);
            e = '{32'h0, 32'h0};
        end else begin
            e = sb.pop_front();
        end
        chk($sformatf("v%0d valid", idx), 32'(inst_valid), 32'd1);
        chk($sformatf("v%0d req_valid", idx), 32'(imem_req), 32'd0);
        chk($sformatf("v%0d inst", idx), inst, e.inst);
        chk($sformatf("v%0d ctl_op", idx), 32'(ctl_op), 32'(e.inst[31:26]));
        chk($sformatf("v%0d pc_plus4", idx), pc_plus4, e.pc4);
        chk($sformatf("v%0d addr_valid", idx), imem_addr, e.pc4);
        branch        = v.br;
        zero          = v.z;
        branch_offset = v.off;
        if (v.stall_cyc > 0) begin
            stall      = 1'b1;
            imem_ready = 1'b1;   // must be ignored outside FETCH
            for (int i = 0; i < v.stall_cyc; i++) begin
                step();
                chk($sformatf("v%0d stall_valid", idx), 32'(inst_valid), 32'd1);
                chk($sformatf("v%0d stall_inst", idx), inst, e.inst);
                chk($sformatf("v%0d stall_pc4", idx), pc_plus4, e.pc4);
                chk($sformatf("v%0d stall_addr", idx), imem_addr, e.pc4);
            end
        end
        imem_ready = 1'b0;
        stall      = 1'b0;
        step();
        chk($sformatf("v%0d rel_valid", idx), 32'(inst_valid), 32'd0);
        chk($sformatf("v%0d rel_req", idx), 32'(imem_req), 32'd1);
        chk($sformatf("v%0d next_addr", idx), imem_addr, v.exp_next);
        branch = 1'b0;
        zero   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          delay stall br    z     offset         addr    next
        vecs[0] = '{0, 0, 1'b0, 1'b0, 32'h0000_0000, 32'd0,  32'd4};
        vecs[1] = '{0, 4, 1'b1, 1'b1, 32'h0000_0003, 32'd4,  32'd20};
        vecs[2] = '{3, 0, 1'b1, 1'b0, 32'h0000_0005, 32'd20, 32'd24};
        vecs[3] = '{0, 0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'd24, 32'd12};
        vecs[4] = '{0, 0, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'd12, 32'd8};
        vecs[5] = '{1, 2, 1'b0, 1'b1, 32'h0000_0007, 32'd8,  32'd12};
        vecs[6] = '{0, 0, 1'b1, 1'b1, 32'h4000_0001, 32'd12, 32'd20};
        vecs[7] = '{2, 0, 1'b0, 1'b0, 32'h0000_0000, 32'd20, 32'd24};

        reset = 1'b1; imem_ready = 1'b0; stall = 1'b0;
        branch = 1'b0; zero = 1'b0; branch_offset = '0;
        w_reset = 1'b1; w_ready = 1'b1; w_stall = 1'b0;
        w_branch = 1'b0; w_zero = 1'b0; w_off = '0;

        repeat (3) step();
        chk("rst req", 32'(imem_req), 32'd0);
        chk("rst valid", 32'(inst_valid), 32'd0);
        chk("rst inst", inst, 32'h0);
        chk("rst ctl_op", 32'(ctl_op), 32'h0);
        chk("rst pc_plus4", pc_plus4, 32'd4);
        chk("rst addr", imem_addr, 32'h0);
        chk("wrap rst addr", w_addr, 32'hFFFF_FFFC);
        chk("wrap rst pc_plus4", w_pc4, 32'h0);
        chk("wrap rst req", 32'(w_req), 32'd0);

        reset = 1'b0;
        chk("rst_wait req", 32'(imem_req), 32'd0);
        step();
        for (int i = 0; i < 8; i++) fetch_one(i, vecs[i]);

        // Reset while FETCH waits on ready; a late ready must be dropped.
        imem_ready = 1'b0;
        step();
        chk("midrst pre_req", 32'(imem_req), 32'd1);
        reset = 1'b1;
        step();
        chk("midrst req", 32'(imem_req), 32'd0);
        chk("midrst valid", 32'(inst_valid), 32'd0);
        chk("midrst addr", imem_addr, 32'h0);
        chk("midrst pc_plus4", pc_plus4, 32'd4);
        chk("midrst inst", inst, 32'h0);
        imem_ready = 1'b1;
        step();
        chk("midrst hold_req", 32'(imem_req), 32'd0);
        chk("midrst hold_inst", inst, 32'h0);
        reset = 1'b0;
        step();
        chk("restart req", 32'(imem_req), 32'd1);
        chk("restart addr", imem_addr, 32'h0);
        chk("restart valid", 32'(inst_valid), 32'd0);
        chk("restart inst", inst, 32'h0);
        step();
        imem_ready = 1'b0;
        chk("restart cap_valid", 32'(inst_valid), 32'd1);
        chk("restart cap_inst", inst, 32'h8C22_0004);
        chk("restart cap_op", 32'(ctl_op), 32'(OP_LW));
        chk("restart cap_pc4", pc_plus4, 32'd4);

        // Sequential fetch across the top of the address space.
        w_reset = 1'b0;
        step();
        chk("wrap req1", 32'(w_req), 32'd1);
        chk("wrap addr1", w_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap valid1", 32'(w_valid), 32'd1);
        chk("wrap inst1", w_inst, mem_word(32'hFFFF_FFFC));
        chk("wrap pc4_1", w_pc4, 32'h0);
        step();
        chk("wrap req2", 32'(w_req), 32'd1);
        chk("wrap addr2", w_addr, 32'h0);
        step();
        chk("wrap inst2", w_inst, 32'h8C22_0004);
        chk("wrap pc4_2", w_pc4, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
